// File: rtl/csram_sweep_pkg.sv
// Shared types and defaults for the CSRAM sweep controller.
// CSRAM_SWEEP_SKIP_UNCHANGED_EN (optional) skips write-back of unchanged potentials.
package csram_sweep_pkg;

    localparam int DEF_NUM_NEURONS = 256;
    localparam int DEF_WIDTH       = 367;
    localparam int DEF_WRITE_INDEX = 102;
    localparam int DEF_WRITE_WIDTH = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_OFFER,
        S_WAIT_POT,
        S_WRITE,
        S_DONE
    } sweep_state_t;

    function automatic logic [DEF_WIDTH-1:0] merge_potential(
        input logic [DEF_WIDTH-1:0]       word,
        input logic [DEF_WRITE_WIDTH-1:0] pot
    );
        logic [DEF_WIDTH-1:0] merged;
        merged = word;
        merged[DEF_WRITE_INDEX +: DEF_WRITE_WIDTH] = pot;
        return merged;
    endfunction

endpackage

// File: rtl/csram_field_merge.sv
// Combinational insert of the potential field into a CSRAM word.
// No configuration macros.
module csram_field_merge
    import csram_sweep_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int WRITE_INDEX = DEF_WRITE_INDEX,
    parameter int WRITE_WIDTH = DEF_WRITE_WIDTH
) (
    input  logic [WIDTH-1:0]       word,
    input  logic [WRITE_WIDTH-1:0] pot,
    output logic [WIDTH-1:0]       merged
);

    always_comb begin
        merged = word;
        merged[WRITE_INDEX +: WRITE_WIDTH] = pot;
    end

endmodule

// File: rtl/csram_sweep_controller.sv
// Per-tick CSRAM read-modify-write sweep feeding the neuron update unit.
// CSRAM_SWEEP_SKIP_UNCHANGED_EN: skip WRITE when the potential is unchanged.
module csram_sweep_controller
    import csram_sweep_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int WRITE_INDEX = DEF_WRITE_INDEX,
    parameter int WRITE_WIDTH = DEF_WRITE_WIDTH,
    localparam int AW         = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    output logic                   csram_wen,
    output logic [AW-1:0]          csram_address,
    output logic [WIDTH-1:0]       csram_data_in,
    input  logic [WIDTH-1:0]       csram_data_out,
    output logic                   param_valid,
    input  logic                   param_ready,
    output logic [WIDTH-1:0]       param_word,
    output logic [AW-1:0]          param_index,
    input  logic                   pot_valid,
    input  logic [WRITE_WIDTH-1:0] pot_in,
    output logic                   busy,
    output logic                   sweep_done,
    output logic                   tick_overrun
);

    sweep_state_t           state;
    sweep_state_t           state_next;
    logic [AW-1:0]          idx;
    logic [WIDTH-1:0]       word_q;
    logic [WRITE_WIDTH-1:0] pot_q;
    logic                   last;
    logic                   skip;

    assign last = (idx == AW'(NUM_NEURONS - 1));

`ifdef CSRAM_SWEEP_SKIP_UNCHANGED_EN
    assign skip = (pot_in == word_q[WRITE_INDEX +: WRITE_WIDTH]);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:     if (tick) state_next = S_FETCH;
            S_FETCH:    state_next = S_CAPTURE;
            S_CAPTURE:  state_next = S_OFFER;
            S_OFFER:    if (param_ready) state_next = S_WAIT_POT;
            S_WAIT_POT: begin
                if (pot_valid) begin
                    if (!skip)     state_next = S_WRITE;
                    else if (last) state_next = S_DONE;
                    else           state_next = S_FETCH;
                end
            end
            S_WRITE:    state_next = last ? S_DONE : S_FETCH;
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        csram_wen   = (state == S_WRITE);
        param_valid = (state == S_OFFER);
        busy        = (state != S_IDLE);
        sweep_done  = (state == S_DONE);
    end

    // Datapath: idx counter, fetched word, sampled potential, overrun flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx          <= '0;
            word_q       <= '0;
            param_index  <= '0;
            pot_q        <= '0;
            tick_overrun <= 1'b0;
        end else begin
            if (tick && state != S_IDLE) tick_overrun <= 1'b1;
            unique case (state)
                S_IDLE: if (tick) idx <= '0;
                S_CAPTURE: begin
                    word_q      <= csram_data_out;
                    param_index <= idx;
                end
                S_WAIT_POT: begin
                    if (pot_valid) begin
                        pot_q <= pot_in;
                        if (skip && !last) idx <= idx + AW'(1);
                    end
                end
                S_WRITE: if (!last) idx <= idx + AW'(1);
                default: ;
            endcase
        end
    end

    assign csram_address = idx;
    assign param_word    = word_q;

    csram_field_merge #(
        .WIDTH       (WIDTH),
        .WRITE_INDEX (WRITE_INDEX),
        .WRITE_WIDTH (WRITE_WIDTH)
    ) u_merge (
        .word   (word_q),
        .pot    (pot_q),
        .merged (csram_data_in)
    );

endmodule

// File: tb/tb_csram_sweep_controller.sv
// Scoreboard bench for csram_sweep_controller with a CSRAM and neuron-unit model.
// Builds the skip-unchanged scenario when CSRAM_SWEEP_SKIP_UNCHANGED_EN is defined.
module tb_csram_sweep_controller;

    localparam int N  = 4;
    localparam int W  = 367;
    localparam int WI = 102;
    localparam int WW = 9;
    localparam int AW = 2;

    typedef struct {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } wb_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic          csram_wen;
    logic [AW-1:0] csram_address;
    logic [W-1:0]  csram_data_in;
    logic [W-1:0]  csram_data_out = '0;
    logic          param_valid;
    logic          param_ready;
    logic [W-1:0]  param_word;
    logic [AW-1:0] param_index;
    logic          pot_valid;
    logic [WW-1:0] pot_in;
    logic          busy;
    logic          sweep_done;
    logic          tick_overrun;

    logic [W-1:0]  mem [N];
    logic [WW-1:0] pot_tab [N];
    wb_t           exp_q [$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            wr_cnt [N];
    int            n_wr = 0;
    int            n_done = 0;
    int            n_stall = 0;
    int            stall_limit = 0;
    int            stall_seen = 0;
    logic [AW-1:0] stall_idx = '0;
    logic [W-1:0]  stall_word;
    logic [AW-1:0] stall_index;

    always #5 clk = ~clk;

    csram_sweep_controller #(
        .NUM_NEURONS (N),
        .WIDTH       (W),
        .WRITE_INDEX (WI),
        .WRITE_WIDTH (WW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tick           (tick),
        .csram_wen      (csram_wen),
        .csram_address  (csram_address),
        .csram_data_in  (csram_data_in),
        .csram_data_out (csram_data_out),
        .param_valid    (param_valid),
        .param_ready    (param_ready),
        .param_word     (param_word),
        .param_index    (param_index),
        .pot_valid      (pot_valid),
        .pot_in         (pot_in),
        .busy           (busy),
        .sweep_done     (sweep_done),
        .tick_overrun   (tick_overrun)
    );

    assign pot_valid   = 1'b1;
    assign pot_in      = pot_tab[param_index];
    assign param_ready = !(param_valid && param_index == stall_idx
                           && stall_seen < stall_limit);

    always @(posedge clk) begin
        if (!param_valid) stall_seen <= 0;
        else if (!param_ready) stall_seen <= stall_seen + 1;
    end

    // CSRAM model: falling-edge clocked, no read while writing
    always @(negedge clk) begin
        if (csram_wen) mem[csram_address] = csram_data_in;
        else csram_data_out = mem[csram_address];
    end

    function automatic void chk(string name, logic [W-1:0] got,
                                logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    function automatic logic [W-1:0] merge_ref(logic [W-1:0] w,
                                               logic [WW-1:0] p);
        logic [W-1:0] r;
        for (int b = 0; b < W; b++)
            r[b] = (b >= WI && b < WI + WW) ? p[b-WI] : w[b];
        return r;
    endfunction

    function automatic logic [WW-1:0] field_of(logic [W-1:0] w);
        return w[WI +: WW];
    endfunction

    // Monitor: pops the scoreboard on every write-back
    always @(negedge clk) begin
        if (csram_wen) begin
            wr_cnt[csram_address]++;
            n_wr++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", W'(csram_address), W'(N));
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_addr", W'(csram_address), W'(e.a));
                chk("wb_data", csram_data_in, e.d);
            end
        end
        if (sweep_done) n_done++;
        if (param_valid && !param_ready) begin
            n_stall++;
            chk("stall_wen", W'(csram_wen), W'(0));
            if (n_stall == 1) begin
                stall_word  = param_word;
                stall_index = param_index;
            end else begin
                chk("stall_word", param_word, stall_word);
                chk("stall_index", W'(param_index), W'(stall_index));
            end
        end
    end

    task automatic init_mem();
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] w;
            for (int b = 0; b < W; b++) w[b] = ((b * 7 + i * 13) % 5) == 0;
            mem[i] = w;
        end
        mem[2] = '1;
        for (int i = 0; i < N; i++) pot_tab[i] = ~field_of(mem[i]);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) wr_cnt[i] = 0;
        n_wr = 0;
        n_done = 0;
        n_stall = 0;
    endtask

    task automatic push_exp();
        for (int i = 0; i < N; i++) begin
            wb_t e;
            e.a = AW'(i);
            e.d = merge_ref(mem[i], pot_tab[i]);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_tick();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
    endtask

    task automatic wait_done(input int start, output int n);
        n = start;
        while (!sweep_done && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_once(string name);
        for (int i = 0; i < N; i++) chk(name, W'(wr_cnt[i]), W'(1));
        chk("queue_empty", W'(exp_q.size()), W'(0));
    endtask

    task automatic check_zero_outs(string name);
        chk(name, W'({csram_wen, csram_address, param_valid, param_index,
                      busy, sweep_done, tick_overrun}), W'(0));
        chk({name, "_data_in"}, csram_data_in, '0);
        chk({name, "_param_word"}, param_word, '0);
    endtask

    initial begin
        int n;
        int k;
        logic [W-1:0] exp2;

        init_mem();
        clear_counts();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_zero_outs("reset_outs");

        // best-case sweep with word 2 all ones
        push_exp();
        do_tick();
        chk("busy_started", W'(busy), W'(1));
        wait_done(1, n);
        chk("sweep_cycles", W'(n), W'(21));
        repeat (2) @(posedge clk);
        #1;
        chk("busy_idle", W'(busy), W'(0));
        check_once("write_once");
        chk("done_pulses", W'(n_done), W'(1));
        exp2 = '1;
        for (int b = 102; b <= 110; b++) exp2[b] = 1'b0;
        chk("word2_writeback", mem[2], exp2);

        // param_ready stall at neuron 1
        init_mem();
        clear_counts();
        stall_idx = 2'd1;
        stall_limit = 7;
        push_exp();
        do_tick();
        wait_done(1, n);
        chk("stall_cycles", W'(n), W'(28));
        repeat (2) @(posedge clk);
        #1;
        chk("stall_count", W'(n_stall), W'(7));
        check_once("stall_write_once");
        stall_limit = 0;

        // second tick three cycles after the first
        init_mem();
        clear_counts();
        push_exp();
        do_tick();
        @(posedge clk); #1;
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        wait_done(4, n);
        chk("overrun_cycles", W'(n), W'(21));
        repeat (10) @(posedge clk);
        #1;
        chk("overrun_flag", W'(tick_overrun), W'(1));
        chk("overrun_done", W'(n_done), W'(1));
        chk("overrun_writes", W'(n_wr), W'(N));
        chk("overrun_busy", W'(busy), W'(0));

        // reset during WRITE of neuron 2, with a tick in the reset cycle
        init_mem();
        clear_counts();
        push_exp();
        do_tick();
        k = 0;
        while (!(csram_wen && csram_address == 2'd2) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("reach_write2", W'(csram_wen && csram_address == 2'd2), W'(1));
        rst_n = 1'b0;
        tick = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick = 1'b0;
        check_zero_outs("abort_outs");
        exp_q.delete();
        @(posedge clk); #1;
        chk("abort_tick_ignored", W'(busy), W'(0));
        init_mem();
        clear_counts();
        push_exp();
        do_tick();
        wait_done(1, n);
        chk("restart_cycles", W'(n), W'(21));
        repeat (2) @(posedge clk);
        #1;
        check_once("restart_write_once");

`ifdef CSRAM_SWEEP_SKIP_UNCHANGED_EN
        // unchanged potentials: no write-back at all
        init_mem();
        clear_counts();
        for (int i = 0; i < N; i++) pot_tab[i] = field_of(mem[i]);
        do_tick();
        wait_done(1, n);
        chk("skip_cycles", W'(n), W'(17));
        repeat (2) @(posedge clk);
        #1;
        chk("skip_writes", W'(n_wr), W'(0));
        chk("skip_done", W'(n_done), W'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
